// File: rtl/psub_pkg.sv
// psub_pkg
//   Shared constants and types for the sequential packed saturating subtractor.
//   LANES / LANE_W set the packed geometry, SAT_POS / SAT_NEG are the clamp
//   values for a two's complement lane, and state_e names the controller states.
package psub_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = 4;
  localparam int DATA_W = LANES * LANE_W;
  localparam int CNT_W  = $clog2(LANES);

  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(LANES - 1);
  localparam logic [LANE_W-1:0] SAT_POS  = {1'b0, {(LANE_W-1){1'b1}}};
  localparam logic [LANE_W-1:0] SAT_NEG  = {1'b1, {(LANE_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : psub_pkg

// File: rtl/psub_lane.sv
// psub_lane
//   Combinational single-lane saturating subtract r = sat(a - b).
//   Ports:
//     a   in  LANE_W  minuend lane (two's complement)
//     b   in  LANE_W  subtrahend lane (two's complement)
//     r   out LANE_W  saturated difference
//     ovf out 1       signed overflow occurred (r was clamped)
module psub_lane
  import psub_pkg::*;
(
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  output logic [LANE_W-1:0] r,
  output logic              ovf
);

  localparam int MSB = LANE_W - 1;
  localparam logic [LANE_W-1:0] ONE = LANE_W'(1);

  logic [LANE_W-1:0] diff;

  assign diff = a + ~b + ONE;

  // Overflow is only possible when the operand signs differ; the clamp
  // direction follows the minuend sign, not the carry-out.
  assign ovf = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]);
  assign r   = ovf ? (a[MSB] ? SAT_NEG : SAT_POS) : diff;

endmodule : psub_lane

// File: rtl/psubsb_seq.sv
// psubsb_seq
//   Multi-cycle packed saturating subtractor, one lane per clock.
//   An op is accepted in IDLE, lanes are computed in BUSY from latched
//   operands, and the result is presented in DONE until consumed.
//   Ports:
//     clk       in  1       clock, rising edge
//     rst_n     in  1       asynchronous active-low reset
//     flush     in  1       synchronous abort, returns to IDLE
//     in_valid  in  1       operands valid
//     in_ready  out 1       unit idle and can accept
//     A         in  DATA_W  packed minuend
//     B         in  DATA_W  packed subtrahend
//     out_valid out 1       S/v valid
//     out_ready in  1       consumer accepts S/v
//     S         out DATA_W  packed saturated difference
//     v         out LANES   per-lane overflow flags
module psubsb_seq
  import psub_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] S,
  output logic [LANES-1:0]  v
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  a_q, a_d;
  logic [DATA_W-1:0]  b_q, b_d;
  logic [DATA_W-1:0]  s_q, s_d;
  logic [LANES-1:0]   v_q, v_d;

  logic [LANE_W-1:0]  lane_a, lane_b, lane_r;
  logic               lane_ovf;

  // Select the lane addressed by cnt from the latched operands.
  always_comb begin
    lane_a = '0;
    lane_b = '0;
    for (int i = 0; i < LANES; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        lane_a = a_q[i*LANE_W +: LANE_W];
        lane_b = b_q[i*LANE_W +: LANE_W];
      end
    end
  end

  psub_lane u_lane (
    .a   (lane_a),
    .b   (lane_b),
    .r   (lane_r),
    .ovf (lane_ovf)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    v_d     = v_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          s_d     = '0;
          v_d     = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int i = 0; i < LANES; i++) begin
          if (cnt_q == CNT_W'(i)) begin
            s_d[i*LANE_W +: LANE_W] = lane_r;
            v_d[i]                  = lane_ovf;
          end
        end
        // cnt parks at the last lane through DONE and is cleared on the way back to IDLE.
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // flush overrides everything: no accept, no lane write, back to IDLE.
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      a_d     = a_q;
      b_d     = b_q;
      s_d     = s_q;
      v_d     = v_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      v_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      v_q     <= v_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign S         = s_q;
  assign v         = v_q;

endmodule : psubsb_seq

// File: tb/tb_psubsb_seq.sv
// tb_psubsb_seq
//   Self-checking bench for psubsb_seq. Expected {S, v} pairs come from an
//   integer-range reference model and are queued when an op is driven, then
//   popped and compared when out_valid rises. Inputs are driven and outputs
//   sampled on the falling clock edge.
module tb_psubsb_seq;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] S;
  logic [3:0]  v;

  int vectors;
  int miscompares;

  logic [19:0] exp_q[$];

  psubsb_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .v         (v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact signed difference in int, then clamp to [-8, 7].
  function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b);
    logic [15:0]       s;
    logic [3:0]        ov;
    logic signed [3:0] as;
    logic signed [3:0] bs;
    int                d;
    s  = '0;
    ov = '0;
    for (int i = 0; i < 4; i++) begin
      as = a[i*4 +: 4];
      bs = b[i*4 +: 4];
      d  = int'(as) - int'(bs);
      if (d > 7) begin
        s[i*4 +: 4] = 4'h7;
        ov[i] = 1'b1;
      end else if (d < -8) begin
        s[i*4 +: 4] = 4'h8;
        ov[i] = 1'b1;
      end else begin
        s[i*4 +: 4] = d[3:0];
      end
    end
    return {s, ov};
  endfunction

  // Drive one op starting at a falling edge; returns at the falling edge right
  // after the accepting rising edge, with operand inputs scrambled.
  task automatic issue_op(input logic [15:0] a, input logic [15:0] b, input bit push);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b1;
    A = a;
    B = b;
    if (push) exp_q.push_back(model(a, b));
    @(negedge clk);
    in_valid = 1'b0;
    A = 16'($urandom);
    B = 16'($urandom);
  endtask

  // Count falling edges (including the current one) until out_valid is seen.
  task automatic wait_done(output int cycles, output bit timeout);
    cycles  = 1;
    timeout = 1'b0;
    while (!out_valid && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    if (!out_valid) timeout = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || S !== 16'h0 || v !== 4'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: in_ready=%b out_valid=%b S=%h v=%b, required 1 0 0000 0000",
               in_ready, out_valid, S, v);
    end
    in_valid = 1'b1;
    A = 16'h1111;
    B = 16'h2222;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_hold: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    logic [15:0] av[4];
    logic [15:0] bv[4];
    logic [19:0] e;
    int          cyc;
    bit          to;
    av = '{16'h7830, 16'h1234, 16'h8888, 16'h7F80};
    bv = '{16'h8150, 16'h1234, 16'h7777, 16'h0801};
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k < 4) issue_op(av[k], bv[k], 1'b1);
      else issue_op(16'($urandom), 16'($urandom), 1'b1);
      vectors++;
      if (in_ready !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL busy_in_ready op%0d: got %b, required 0", k, in_ready);
      end
      wait_done(cyc, to);
      vectors++;
      if (to || cyc != 5) begin
        miscompares++;
        $display("[TB] FAIL latency op%0d: got %0d cycles (timeout=%0d), required 5", k, cyc, to);
      end
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL scoreboard_empty op%0d: got no expected entry, required one", k);
      end else begin
        e = exp_q.pop_front();
        if ({S, v} !== e) begin
          miscompares++;
          $display("[TB] FAIL result op%0d: S=%h v=%b, required S=%h v=%b", k, S, v, e[19:4], e[3:0]);
        end
      end
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL one_cycle_valid op%0d: out_valid=%b in_ready=%b, required 0 1",
                 k, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [19:0] e;
    int          cyc;
    bit          to;
    out_ready = 1'b0;
    issue_op(16'h3A5C, 16'hC5A3, 1'b1);
    wait_done(cyc, to);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 20'hx;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (to || out_valid !== 1'b1 || in_ready !== 1'b0 || {S, v} !== e) begin
        miscompares++;
        $display("[TB] FAIL hold_done c%0d: out_valid=%b in_ready=%b S=%h v=%b, required 1 0 S=%h v=%b",
                 k, out_valid, in_ready, S, v, e[19:4], e[3:0]);
      end
      if (k < 3) @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL release_done: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
    // Next op goes in on this very cycle.
    issue_op(16'h0F0F, 16'h1010, 1'b1);
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL next_accept: in_ready=%b, required 0", in_ready);
    end
    wait_done(cyc, to);
    vectors++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 20'hx;
    if (to || {S, v} !== e) begin
      miscompares++;
      $display("[TB] FAIL next_result: S=%h v=%b, required S=%h v=%b", S, v, e[19:4], e[3:0]);
    end
    @(negedge clk);
  endtask

  task automatic test_flush;
    logic [19:0] e;
    int          cyc;
    bit          to;
    bit          seen;
    out_ready = 1'b1;
    issue_op(16'h5555, 16'hAAAA, 1'b0);
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL flush_busy: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("[TB] FAIL flush_no_valid: out_valid rose=%b, required 0", seen);
    end
    // flush together with in_valid in IDLE must not accept.
    flush = 1'b1;
    in_valid = 1'b1;
    A = 16'h1111;
    B = 16'h2222;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL flush_idle_accept: in_ready=%b, required 1", in_ready);
    end
    issue_op(16'h0007, 16'h000F, 1'b1);
    wait_done(cyc, to);
    vectors++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 20'hx;
    if (to || cyc != 5 || {S, v} !== e) begin
      miscompares++;
      $display("[TB] FAIL after_flush: S=%h v=%b cycles=%0d, required S=%h v=%b cycles=5",
               S, v, cyc, e[19:4], e[3:0]);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset;
    logic [19:0] e;
    int          cyc;
    bit          to;
    out_ready = 1'b1;
    issue_op(16'h7777, 16'h1111, 1'b0);
    @(negedge clk);
    vectors++;
    if (S !== 16'h0006 || v !== 4'h0) begin
      miscompares++;
      $display("[TB] FAIL partial_lanes: S=%h v=%b, required S=0006 v=0000", S, v);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || S !== 16'h0 || v !== 4'h0) begin
      miscompares++;
      $display("[TB] FAIL async_reset: in_ready=%b out_valid=%b S=%h v=%b, required 1 0 0000 0000",
               in_ready, out_valid, S, v);
    end
    @(negedge clk);
    rst_n = 1'b1;
    issue_op(16'hF0E1, 16'h1F2E, 1'b1);
    wait_done(cyc, to);
    vectors++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 20'hx;
    if (to || {S, v} !== e) begin
      miscompares++;
      $display("[TB] FAIL after_reset: S=%h v=%b, required S=%h v=%b", S, v, e[19:4], e[3:0]);
    end
    @(negedge clk);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    flush       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    A           = '0;
    B           = '0;

    test_reset();
    test_basic();
    test_backpressure();
    test_flush();
    test_async_reset();

    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_psubsb_seq
